// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter/sequencer for the unified memory map.
// Master 0 is the CPU and master 1 is the DMA/loader. The winner's request is latched
// and driven onto the single memory port. The block waits out the one-cycle sync-read
// latency, then returns registered read data and a one-cycle ack.
// Optional build macro: MEM_ARB_ROM_WP_EN. When defined, a write below ROM_TOP is not
// sent to memory; the owner gets its ack with the err flag set.
module mem_bus_arbiter #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ARB_MODE = 0,
    parameter logic [ADDR_W-1:0] ROM_TOP  = 8'h80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              grant_id
);

`ifdef MEM_ARB_ROM_WP_EN
    localparam bit WpEn = 1'b1;
`else
    localparam bit WpEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StIssue, StRdWait, StDone} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              wp_q, wp_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_write_q, mem_write_d;
    logic              busy_q, busy_d;
    logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    logic              win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_wp;

    // Winner selection and the winner's request fields
    always_comb begin
        win = 1'b0;
        if (m0_req && m1_req) begin
            win = (ARB_MODE == 1) ? 1'b0 : ~last_grant_q;
        end else if (m1_req) begin
            win = 1'b1;
        end
        sel_we    = win ? m1_we    : m0_we;
        sel_addr  = win ? m1_addr  : m0_addr;
        sel_wdata = win ? m1_wdata : m0_wdata;
        sel_wp    = WpEn && sel_we && (sel_addr < ROM_TOP);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        wp_d         = wp_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_write_d  = 1'b0;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_err_d     = m0_err_q;
        m1_err_d     = m1_err_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;

        case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    owner_d     = win;
                    we_d        = sel_we;
                    wp_d        = sel_wp;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    // Write strobe is high only while in ISSUE; a protected write never strobes
                    mem_write_d = sel_we && !sel_wp;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (we_q) begin
                    m0_ack_d = ~owner_q;
                    m1_ack_d = owner_q;
                    if (owner_q) m1_err_d = wp_q;
                    else         m0_err_d = wp_q;
                    state_d = StDone;
                end else begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                // Memory data for the address presented in ISSUE is valid now
                if (owner_q) begin
                    m1_rdata_d = mem_data_out;
                    m1_err_d   = 1'b0;
                end else begin
                    m0_rdata_d = mem_data_out;
                    m0_err_d   = 1'b0;
                end
                m0_ack_d = ~owner_q;
                m1_ack_d = owner_q;
                state_d  = StDone;
            end
            StDone: begin
                last_grant_d = owner_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset aborts any transaction without an ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            wp_q         <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_write_q  <= 1'b0;
            busy_q       <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            wp_q         <= wp_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_write_q  <= mem_write_d;
            busy_q       <= busy_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_err_q     <= m0_err_d;
            m1_err_q     <= m1_err_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign mem_address = addr_q;
    assign mem_write   = mem_write_q;
    assign mem_data_in = wdata_q;
    assign busy        = busy_q;
    assign grant_id    = owner_q;
    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_err      = m0_err_q;
    assign m1_err      = m1_err_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin instance (scoreboarded) and a fixed-priority
// instance sharing the same master inputs, each with its own sync memory model.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_ROM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, mem_init;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic       m0_ack, m0_err, m1_ack, m1_err, mem_write, busy, grant_id;
    logic [7:0] m0_rdata, m1_rdata, mem_address, mem_data_in, mem_data_out;

    logic       f_m0_ack, f_m0_err, f_m1_ack, f_m1_err, f_mem_write, f_busy, f_grant_id;
    logic [7:0] f_m0_rdata, f_m1_rdata, f_mem_address, f_mem_data_in, f_mem_data_out;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .ARB_MODE(0), .ROM_TOP(8'h80)) u_rr (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_address(mem_address), .mem_write(mem_write), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .busy(busy), .grant_id(grant_id)
    );

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .ARB_MODE(1), .ROM_TOP(8'h80)) u_fix (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(f_m0_ack), .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(f_m1_ack), .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
        .mem_address(f_mem_address), .mem_write(f_mem_write), .mem_data_in(f_mem_data_in),
        .mem_data_out(f_mem_data_out), .busy(f_busy), .grant_id(f_grant_id)
    );

    // Memory map model: ROM 00-7F read-only, RAM 80-DF, hole E0-EF reads 0, I/O F0-FF
    function automatic logic [7:0] init_val(input logic [7:0] a);
        if (a >= 8'hE0 && a <= 8'hEF) return 8'h00;
        return a ^ 8'h3C;
    endfunction

    function automatic bit writable(input logic [7:0] a);
        return (a >= 8'h80 && a <= 8'hDF) || (a >= 8'hF0);
    endfunction

    logic [7:0] mem_r [256];
    logic [7:0] mem_f [256];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_r[i] <= init_val(8'(i));
        end else if (mem_write && writable(mem_address)) begin
            mem_r[mem_address] <= mem_data_in;
        end
        mem_data_out <= mem_r[mem_address];
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_f[i] <= init_val(8'(i));
        end else if (f_mem_write && writable(f_mem_address)) begin
            mem_f[f_mem_address] <= f_mem_data_in;
        end
        f_mem_data_out <= mem_f[f_mem_address];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-strobe monitor on the round-robin port
    int         wr_cnt = 0;
    logic [7:0] wr_addr_seen, wr_data_seen;
    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            wr_cnt++;
            wr_addr_seen = mem_address;
            wr_data_seen = mem_data_in;
        end
    end

    // Scoreboard: expected completions in order
    typedef struct {
        bit         m;
        logic [7:0] rdata;
        bit         chk_rd;
        bit         err;
    } sb_t;
    sb_t sbq[$];
    bit  mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (m0_ack === 1'b1 && m1_ack === 1'b1) check("both_acks", 1, 0);
            if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ack", {m1_ack, m0_ack}, 0);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    check("ack_owner", m1_ack, e.m);
                    check("grant_id", grant_id, e.m);
                    if (e.chk_rd) check("rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
                    check("err", e.m ? m1_err : m0_err, e.err);
                end
            end
        end
    end

    task automatic drive(input bit m, input bit req, input bit we, input logic [7:0] a,
                         input logic [7:0] d);
        if (m) begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    typedef struct {
        bit         m;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit         err;
        int         lat;
        int         wr;
    } vec_t;
    vec_t vt[11];

    task automatic run_vec(input vec_t v);
        int lat;
        int wbase;
        bit got;
        @(posedge clk); #1;
        drive(v.m, 1'b1, v.we, v.addr, v.wdata);
        sbq.push_back('{m: v.m, rdata: v.rdata, chk_rd: !v.we, err: v.err});
        wbase = wr_cnt;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ((v.m ? m1_ack : m0_ack) === 1'b1) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        if (!got) check("ack_timeout", 0, 1);
        else      check("latency", lat, v.lat);
        @(posedge clk); #1;
        drive(v.m, 1'b0, 1'b0, 8'h00, 8'h00);
        if (v.we) begin
            check("wr_pulses", wr_cnt - wbase, v.wr);
            if (v.wr == 1) begin
                check("wr_addr", wr_addr_seen, v.addr);
                check("wr_data", wr_data_seen, v.wdata);
            end
        end
    endtask

    initial begin
        int n;
        bit got;

        vt[0]  = '{0, 1, 8'h85, 8'hA5, 8'h00, 0, 2, 1};
        vt[1]  = '{0, 0, 8'h85, 8'h00, 8'hA5, 0, 3, 0};
        vt[2]  = '{1, 1, 8'hF3, 8'h5C, 8'h00, 0, 2, 1};
        vt[3]  = '{1, 0, 8'hF3, 8'h00, 8'h5C, 0, 3, 0};
        vt[4]  = '{0, 0, 8'hE5, 8'h00, 8'h00, 0, 3, 0};
        vt[5]  = '{1, 0, 8'h20, 8'h00, 8'h1C, 0, 3, 0};
        vt[6]  = '{0, 1, 8'h10, 8'hFF, 8'h00, WP, 2, WP ? 0 : 1};
        vt[7]  = '{0, 0, 8'h10, 8'h00, 8'h2C, 0, 3, 0};
        vt[8]  = '{1, 1, 8'hDF, 8'h11, 8'h00, 0, 2, 1};
        vt[9]  = '{1, 0, 8'hDF, 8'h00, 8'h11, 0, 3, 0};
        vt[10] = '{0, 0, 8'hF0, 8'h00, 8'hCC, 0, 3, 0};

        reset = 1'b1;
        mem_init = 1'b1;
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mem_init = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_data_in", mem_data_in, 0);
        check("rst_acks", {m1_ack, m0_ack}, 0);
        check("rst_errs", {m1_err, m0_err}, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
        check("rst_fix_busy", f_busy, 0);
        mon_en = 1'b1;

        // Reset while in RD_WAIT aborts with no ack and no captured data
        @(posedge clk); #1 drive(0, 1'b1, 1'b0, 8'h20, 8'h00);
        @(posedge clk);
        @(posedge clk); #1;
        check("rdwait_busy", busy, 1);
        check("rdwait_mem_write", mem_write, 0);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_mem_write", mem_write, 0);
        check("abort_ack", m0_ack, 0);
        check("abort_rdata", m0_rdata, 0);
        check("abort_mem_address", mem_address, 0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(vt[i]);
        check("sb_empty_vec", sbq.size(), 0);

        // Round-robin ties: both hold reads, completions alternate 0,1,0,1
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            sbq.push_back('{m: i[0], rdata: i[0] ? 8'h5C : 8'hA5, chk_rd: 1'b1, err: 1'b0});
        end
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 8'h85, 8'h00);
        drive(1, 1'b1, 1'b0, 8'hF3, 8'h00);
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (m0_ack === 1'b1 || m1_ack === 1'b1) n++;
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        check("rr_tie_acks", n, 4);
        check("sb_empty_rr", sbq.size(), 0);

        // Fixed priority: m0 wins every contended grant; m1 served once m0 drops
        mon_en = 1'b0;
        reset_pulse();
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 8'h85, 8'h00);
        drive(1, 1'b1, 1'b0, 8'hF3, 8'h00);
        n = 0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (f_m0_ack === 1'b1 || f_m1_ack === 1'b1) begin
                check("fix_owner", {f_m1_ack, f_m0_ack}, 2'b01);
                check("fix_rdata", f_m0_rdata, 8'hA5);
                n++;
            end
        end
        check("fix_m0_acks", n, 4);
        @(posedge clk); #1 drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (f_m1_ack === 1'b1) begin
                got = 1'b1;
                check("fix_m1_rdata", f_m1_rdata, 8'h5C);
                break;
            end
        end
        check("fix_m1_served", got, 1);
        @(posedge clk); #1 drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        reset_pulse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
